// File: rtl/des_key_schedule_if.sv
// Handshake bundle between a DES round engine and the subkey generator.
// The generator side is the slave; the requester/consumer side is the master.
interface des_key_schedule_if;
  logic        start;
  logic        decrypt;
  logic [27:0] c_in;
  logic [27:0] d_in;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output start, decrypt, c_in, d_in, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );

  modport slave (
    input  start, decrypt, c_in, d_in, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: streams the 16 round subkeys (forward or reversed) from the
// PC-1 halves C0/D0 over a valid/ready handshake, one subkey per transfer.
module des_key_schedule (
  input  logic              clk,
  input  logic              rst,
  des_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  // FIPS 46-3 PC-2 table; entries are 1-based positions in {C,D}, bit 1 = MSB.
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int j = 0; j < 48; j++) begin
      k[47-j] = cd[56-PC2_TBL[j]];
    end
    return k;
  endfunction

  state_t      state;
  logic [27:0] c_half;
  logic [27:0] d_half;
  logic        dec_mode;
  logic [3:0]  round_cnt;
  logic        valid_flag;
  logic        busy_flag;
  logic        done_flag;

  logic        single_step;
  logic [27:0] c_next;
  logic [27:0] d_next;
  logic        xfer;

  // Both directions take a 1-bit step after emissions 0, 7 and 14, else 2 bits.
  always_comb begin
    single_step = (round_cnt == 4'd0) || (round_cnt == 4'd7) || (round_cnt == 4'd14);
    if (dec_mode) begin
      c_next = rotr(c_half, !single_step);
      d_next = rotr(d_half, !single_step);
    end else begin
      c_next = rotl(c_half, !single_step);
      d_next = rotl(d_half, !single_step);
    end
  end

  assign xfer = valid_flag && bus.subkey_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      c_half     <= '0;
      d_half     <= '0;
      dec_mode   <= 1'b0;
      round_cnt  <= '0;
      valid_flag <= 1'b0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dec_mode   <= bus.decrypt;
            // Decrypt starts from C16/D16, which equal C0/D0.
            c_half     <= bus.decrypt ? bus.c_in : rotl(bus.c_in, 1'b0);
            d_half     <= bus.decrypt ? bus.d_in : rotl(bus.d_in, 1'b0);
            round_cnt  <= '0;
            valid_flag <= 1'b1;
            busy_flag  <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (round_cnt == 4'd15) begin
              round_cnt  <= '0;
              valid_flag <= 1'b0;
              done_flag  <= 1'b1;
              state      <= DONE;
            end else begin
              round_cnt <= round_cnt + 4'd1;
              c_half    <= c_next;
              d_half    <= d_next;
            end
          end
        end
        DONE: begin
          done_flag <= 1'b0;
          busy_flag <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          valid_flag <= 1'b0;
          busy_flag  <= 1'b0;
          done_flag  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.subkey       = valid_flag ? pc2({c_half, d_half}) : 48'h0;
  assign bus.subkey_valid = valid_flag;
  assign bus.round        = round_cnt;
  assign bus.busy         = busy_flag;
  assign bus.done         = done_flag;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed and randomized bench for des_key_schedule; FIPS 46-3 worked-example
// key (C0=F0CCAAF, D0=556678F) provides the hand-computed subkeys.
module tb_des_key_schedule;

  localparam logic [27:0] KC0 = 28'hF0CCAAF;
  localparam logic [27:0] KD0 = 28'h556678F;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC2_REF [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] got [16];
  logic [47:0] enc [16];

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Kn from scratch: cumulative left shift of C0/D0, then PC-2.
  function automatic logic [47:0] ref_key(input logic [27:0] c0, input logic [27:0] d0, input int n);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] k;
    int tot;
    c = c0;
    d = d0;
    tot = 0;
    for (int i = 0; i < n; i++) tot += SHIFTS[i];
    for (int i = 0; i < tot; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    k = '0;
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_REF[j]];
    return k;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.decrypt = 1'b0;
    bus.c_in = '0;
    bus.d_in = '0;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller asserts start on the current negedge (cycle 1); records transfers into got[].
  task automatic collect(input bit rand_ready, input bit scramble,
                         output int n_got, output int done_cyc, output int order_bad);
    int cyc;
    bit fin;
    n_got = 0;
    done_cyc = 0;
    order_bad = 0;
    cyc = 1;
    fin = 1'b0;
    for (int t = 0; t < 300 && !fin; t++) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (scramble) begin
        bus.c_in = 28'($urandom);
        bus.d_in = 28'($urandom);
        bus.decrypt = 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
      if (bus.subkey_valid) begin
        if (rand_ready) bus.subkey_ready = 1'($urandom_range(0, 1));
        if (bus.subkey_ready) begin
          if (n_got < 16) got[n_got] = bus.subkey;
          if (bus.round != n_got[3:0]) order_bad++;
          n_got++;
        end
      end
    end
    bus.subkey_ready = 1'b1;
  endtask

  task automatic launch(input logic dec, input logic [27:0] c, input logic [27:0] d);
    @(negedge clk);
    bus.c_in = c;
    bus.d_in = d;
    bus.decrypt = dec;
    bus.subkey_ready = 1'b1;
    bus.start = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.subkey !== 48'h0) begin errors++; $display("FAIL rst_subkey got=%h exp=0", bus.subkey); end
    if (bus.subkey_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.subkey_valid); end
    if (bus.round !== 4'd0) begin errors++; $display("FAIL rst_round got=%0d exp=0", bus.round); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_encrypt();
    int n, dc, ob;
    launch(1'b0, KC0, KD0);
    collect(1'b0, 1'b0, n, dc, ob);
    checks += 6;
    if (got[0] !== K1) begin errors++; $display("FAIL enc_round0 got=%h exp=%h", got[0], K1); end
    if (got[1] !== K2) begin errors++; $display("FAIL enc_round1 got=%h exp=%h", got[1], K2); end
    if (got[15] !== K16) begin errors++; $display("FAIL enc_round15 got=%h exp=%h", got[15], K16); end
    if (n != 16) begin errors++; $display("FAIL enc_count got=%0d exp=16", n); end
    if (dc != 18) begin errors++; $display("FAIL enc_done_cycle got=%0d exp=18", dc); end
    if (ob != 0) begin errors++; $display("FAIL enc_order got=%0d exp=0", ob); end
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL enc_busy_after got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL enc_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_decrypt();
    int n, dc, ob;
    launch(1'b1, KC0, KD0);
    collect(1'b0, 1'b0, n, dc, ob);
    checks += 5;
    if (got[0] !== K16) begin errors++; $display("FAIL dec_round0 got=%h exp=%h", got[0], K16); end
    if (got[14] !== K2) begin errors++; $display("FAIL dec_round14 got=%h exp=%h", got[14], K2); end
    if (got[15] !== K1) begin errors++; $display("FAIL dec_round15 got=%h exp=%h", got[15], K1); end
    if (n != 16) begin errors++; $display("FAIL dec_count got=%0d exp=16", n); end
    if (ob != 0) begin errors++; $display("FAIL dec_order got=%0d exp=0", ob); end
  endtask

  task automatic test_backpressure();
    int n, ob, bad;
    bit fin, stalled;
    logic [47:0] snap;
    n = 0; ob = 0; bad = 0; fin = 1'b0; stalled = 1'b0;
    launch(1'b0, KC0, KD0);
    for (int t = 0; t < 100 && !fin; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) fin = 1'b1;
      if (bus.subkey_valid && bus.round == 4'd3 && !stalled) begin
        stalled = 1'b1;
        snap = bus.subkey;
        bus.subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (bus.subkey !== snap || bus.round !== 4'd3 || bus.subkey_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got=%h/%0d/%b exp=%h/3/1", bus.subkey, bus.round, bus.subkey_valid, snap);
          end
        end
        bus.subkey_ready = 1'b1;
      end
      if (bus.subkey_valid && bus.subkey_ready) begin
        if (n < 16) got[n] = bus.subkey;
        if (bus.round != n[3:0]) ob++;
        n++;
      end
    end
    checks += 3;
    if (n != 16) begin errors++; $display("FAIL bp_count got=%0d exp=16", n); end
    if (ob != 0) begin errors++; $display("FAIL bp_order got=%0d exp=0", ob); end
    for (int i = 0; i < 16; i++) if (got[i] !== ref_key(KC0, KD0, i + 1)) bad++;
    if (bad != 0) begin errors++; $display("FAIL bp_keys got=%0d wrong exp=0", bad); end
  endtask

  task automatic test_ignored_start();
    int n, ob, bad;
    bit fin, poked;
    n = 0; ob = 0; bad = 0; fin = 1'b0; poked = 1'b0;
    launch(1'b0, KC0, KD0);
    for (int t = 0; t < 100 && !fin; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.subkey_valid && bus.round == 4'd7 && !poked) begin
        poked = 1'b1;
        bus.start = 1'b1;
        bus.decrypt = 1'b1;
        bus.c_in = 28'h1234567;
        bus.d_in = 28'h89ABCDE;
      end
      if (bus.subkey_valid && bus.subkey_ready) begin
        if (n < 16) got[n] = bus.subkey;
        if (bus.round != n[3:0]) ob++;
        n++;
      end
      if (bus.done) begin
        fin = 1'b1;
        bus.start = 1'b1;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b exp=0", bus.busy); end
    if (bus.subkey_valid !== 1'b0) begin errors++; $display("FAIL ign_valid_idle got=%b exp=0", bus.subkey_valid); end
    @(negedge clk);
    checks += 4;
    if (bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ign_done_start got=%b/%b exp=0/0", bus.subkey_valid, bus.busy);
    end
    if (n != 16) begin errors++; $display("FAIL ign_count got=%0d exp=16", n); end
    if (ob != 0) begin errors++; $display("FAIL ign_order got=%0d exp=0", ob); end
    for (int i = 0; i < 16; i++) if (got[i] !== ref_key(KC0, KD0, i + 1)) bad++;
    if (bad != 0) begin errors++; $display("FAIL ign_keys got=%0d wrong exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    launch(1'b0, KC0, KD0);
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.subkey_valid && bus.round == 4'd9) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rmid_reach got=0 exp=1"); end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checks += 5;
    if (bus.subkey !== 48'h0) begin errors++; $display("FAIL rmid_subkey got=%h exp=0", bus.subkey); end
    if (bus.subkey_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.subkey_valid); end
    if (bus.round !== 4'd0) begin errors++; $display("FAIL rmid_round got=%0d exp=0", bus.round); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    bus.decrypt = 1'b0;
    bus.c_in = KC0;
    bus.d_in = KD0;
    @(negedge clk);
    bus.start = 1'b0;
    checks += 2;
    if (bus.subkey_valid !== 1'b1 || bus.round !== 4'd0) begin
      errors++; $display("FAIL rmid_restart got=%b/%0d exp=1/0", bus.subkey_valid, bus.round);
    end
    if (bus.subkey !== K1) begin errors++; $display("FAIL rmid_k1 got=%h exp=%h", bus.subkey, K1); end
    do_reset();
  endtask

  task automatic test_random();
    logic [27:0] c, d;
    int n, dc, ob;
    for (int k = 0; k < 3; k++) begin
      c = 28'($urandom);
      d = 28'($urandom);
      launch(1'b0, c, d);
      collect(1'b1, 1'b1, n, dc, ob);
      checks += 2;
      if (n != 16 || ob != 0) begin errors++; $display("FAIL rnd_enc_seq got=%0d/%0d exp=16/0", n, ob); end
      if (dc == 0) begin errors++; $display("FAIL rnd_enc_done got=0 exp=pulse"); end
      for (int i = 0; i < 16; i++) begin
        enc[i] = got[i];
        checks++;
        if (got[i] !== ref_key(c, d, i + 1)) begin
          errors++; $display("FAIL rnd_enc_k%0d got=%h exp=%h", i, got[i], ref_key(c, d, i + 1));
        end
      end
      launch(1'b1, c, d);
      collect(1'b1, 1'b1, n, dc, ob);
      checks += 2;
      if (n != 16 || ob != 0) begin errors++; $display("FAIL rnd_dec_seq got=%0d/%0d exp=16/0", n, ob); end
      if (dc == 0) begin errors++; $display("FAIL rnd_dec_done got=0 exp=pulse"); end
      for (int i = 0; i < 16; i++) begin
        checks += 2;
        if (got[i] !== ref_key(c, d, 16 - i)) begin
          errors++; $display("FAIL rnd_dec_k%0d got=%h exp=%h", i, got[i], ref_key(c, d, 16 - i));
        end
        if (got[i] !== enc[15-i]) begin
          errors++; $display("FAIL rnd_reverse_%0d got=%h exp=%h", i, got[i], enc[15-i]);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.decrypt = 1'b0;
    bus.c_in = '0;
    bus.d_in = '0;
    bus.subkey_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new 16-subkey sequence; sampled only in IDLE.
REQ-005 decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; captured with start.
REQ-006 c_in  input  28  C0 half from the PC-1 stage; c_in[27] = FIPS bit 1.
REQ-007 d_in  input  28  D0 half from the PC-1 stage; d_in[27] = FIPS bit 1.
REQ-008 subkey  output  48  current round subkey; subkey[47] = FIPS bit 1 of Kn.
REQ-009 subkey_valid  output  1  subkey and round are valid.
REQ-010 subkey_ready  input  1  consumer accepts subkey this cycle.
REQ-011 round  output  4  index of the emitted subkey in emission order, 0..15.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the 16th subkey transfer.

Function
REQ-014 States SHALL be IDLE, EMIT and DONE, held in a registered state variable.
- IDLE->EMIT on start.
- EMIT->DONE on the 16th transfer.
- DONE->IDLE unconditionally after one cycle.
REQ-015 In IDLE with start=1, c_in, d_in and decrypt SHALL be registered.
- The state SHALL move to EMIT with round=0 and subkey_valid=1 on the next cycle (latency 1).
- Encrypt: C/D SHALL load rotated left by 1 (C1/D1).
- Decrypt: C/D SHALL load unrotated (C16 = C0).
REQ-016 A transfer SHALL occur on any cycle with subkey_valid=1 and subkey_ready=1.
- Each transfer advances round by 1 and updates C and D for the next round.
REQ-017 While subkey_valid=1 and subkey_ready=0, subkey and round SHALL hold stable.
REQ-018 Encrypt rotation SHALL be a left rotate of C and D independently.
- Shift per round n = 1..16: 1 for n = 1, 2, 9, 16; otherwise 2.
REQ-019 Decrypt rotation SHALL be a right rotate of C and D independently.
- Shift applied before emission index i = 1..15: 1 for i = 1, 8, 15; otherwise 2.
REQ-020 subkey SHALL be combinational PC-2 (FIPS 46-3 table) of the registered {C,D}.
- Concatenation {C,D}[55] = FIPS bit 1.
REQ-021 Rotations SHALL be pure 28-bit wrap-around with no bit loss.
- After the 16th encrypt round, C and D SHALL equal the loaded C0 and D0 (cumulative shift 28).
REQ-022 subkey_valid SHALL be 1 only in EMIT.
- subkey SHALL read 48'h0 whenever subkey_valid = 0.
REQ-023 round SHALL wrap to 0 on entry to DONE.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 A start asserted while busy=1 SHALL be ignored, not queued.
- c_in, d_in and decrypt changes while busy=1 SHALL have no effect.
REQ-026 start in the same cycle as the DONE->IDLE transition SHALL be ignored.
- start is accepted only on a cycle spent in IDLE.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE from any state, including mid-sequence, with no partial done pulse.
- After reset: subkey = 48'h0, subkey_valid = 0, round = 0, busy = 0, done = 0.
- Internal C/D and decrypt registers SHALL clear to 0.
REQ-028 rst SHALL take priority over start on the same edge.

Verification
REQ-029 The bench SHALL cover, at minimum, the following scenarios.
- Encrypt, subkey_ready held 1, c_in=28'hF0CCAAF, d_in=28'h556678F, start pulse:
  - round 0 subkey = 48'h1B02EFFC7072; round 1 = 48'h79AED9DBC9E5; round 15 = 48'hCB3D8B0E17F5.
  - done pulses exactly 18 cycles after the start edge.
- Same key with decrypt=1: round 0 = 48'hCB3D8B0E17F5, round 14 = 48'h79AED9DBC9E5, round 15 = 48'h1B02EFFC7072.
- Backpressure: subkey_ready=0 for 5 cycles at round 3 -> subkey and round are stable throughout.
  - The sequence resumes with no skipped or duplicated round and completes all 16 subkeys.
- start pulsed at round 7, and again in the DONE cycle -> both ignored; the sequence is unchanged; busy returns to 0.
- rst at round 9 -> next cycle: all outputs at reset values; a subsequent start produces round 0 = 48'h1B02EFFC7072.
- Random C0/D0, both directions, random ready: all 16 subkeys match a reference model; the encrypt and decrypt sequences are exact reverses of each other.
